// File: rtl/ringbus_cmd_decoder.sv
// Ring bus command decoder: pops header/data words and applies mapmov and pilot configuration.
// Optional feature: define RINGBUS_CMD_ACK_EN to send an ack word to ACK_ADDR after each command.
module ringbus_cmd_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter logic [31:0] ACK_ADDR       = 32'h0000_0000
) (
  input  logic        i_sysclk,
  input  logic        i_arst_n,
  input  logic [31:0] i_rd_data,
  input  logic        i_rd_buf_empty,
  output logic        o_rd_en,
  output logic [31:0] o_wr_data,
  output logic [31:0] o_wr_addr,
  output logic        o_start_wr,
  input  logic        i_write_ready,
  input  logic        i_done_wr,
  output logic [31:0] o_trim_start,
  output logic [31:0] o_trim_end,
  output logic [15:0] o_one_value,
  output logic [15:0] o_zero_value,
  output logic [9:0]  o_pilot_addr,
  output logic [31:0] o_pilot_wdata,
  output logic        o_pilot_we,
  output logic        o_mapmov_reset,
  output logic [7:0]  o_err_cnt
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_HDR_WAIT  = 3'd1;
  localparam logic [2:0] S_DECODE    = 3'd2;
  localparam logic [2:0] S_DATA_POP  = 3'd3;
  localparam logic [2:0] S_DATA_WAIT = 3'd4;
  localparam logic [2:0] S_EXEC      = 3'd5;
`ifdef RINGBUS_CMD_ACK_EN
  localparam logic [2:0] S_ACK       = 3'd6;
  localparam logic [2:0] S_POST_EXEC = S_ACK;
`else
  localparam logic [2:0] S_POST_EXEC = S_IDLE;
`endif

  localparam logic [7:0] OP_TRIM_START = 8'h10;
  localparam logic [7:0] OP_TRIM_END   = 8'h11;
  localparam logic [7:0] OP_ONE_ZERO   = 8'h12;
  localparam logic [7:0] OP_PILOT_WR   = 8'h13;
  localparam logic [7:0] OP_MM_RESET   = 8'h14;

  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

  logic [2:0]  state;
  logic [31:0] hdr;
  logic [31:0] data;
  logic [31:0] tmo_cnt;
  logic [7:0]  opcode;

  assign opcode = hdr[31:24];

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // A pop is only offered from the two waiting states, each of which leaves on the pop.
  assign o_rd_en = ((state == S_IDLE) || (state == S_DATA_POP)) && !i_rd_buf_empty;

`ifdef RINGBUS_CMD_ACK_EN
  logic ack_sent;
  assign o_start_wr = (state == S_ACK) && !ack_sent && i_write_ready;
  assign o_wr_addr  = (state == S_ACK) ? ACK_ADDR : 32'h0;
  assign o_wr_data  = (state == S_ACK) ? {8'hA5, opcode, 16'h0000} : 32'h0;
  logic unused_bits;
  assign unused_bits = &{1'b0, hdr[23:10]};
`else
  assign o_start_wr = 1'b0;
  assign o_wr_addr  = 32'h0;
  assign o_wr_data  = 32'h0;
  logic unused_bits;
  assign unused_bits = &{1'b0, hdr[23:10], i_write_ready, i_done_wr, ACK_ADDR};
`endif

  always_ff @(posedge i_sysclk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state          <= S_IDLE;
      hdr            <= 32'h0;
      data           <= 32'h0;
      tmo_cnt        <= 32'h0;
      o_trim_start   <= 32'h0;
      o_trim_end     <= 32'h0;
      o_one_value    <= 16'h0;
      o_zero_value   <= 16'h0;
      o_pilot_addr   <= 10'h0;
      o_pilot_wdata  <= 32'h0;
      o_pilot_we     <= 1'b0;
      o_mapmov_reset <= 1'b0;
      o_err_cnt      <= 8'h0;
`ifdef RINGBUS_CMD_ACK_EN
      ack_sent       <= 1'b0;
`endif
    end else begin
      o_pilot_we     <= 1'b0;
      o_mapmov_reset <= 1'b0;
      case (state)
        S_IDLE:      if (!i_rd_buf_empty) state <= S_HDR_WAIT;
        S_HDR_WAIT: begin
          hdr   <= i_rd_data;
          state <= S_DECODE;
        end
        S_DECODE: begin
          tmo_cnt <= 32'h0;
          case (opcode)
            OP_TRIM_START, OP_TRIM_END, OP_ONE_ZERO, OP_PILOT_WR: state <= S_DATA_POP;
            OP_MM_RESET: state <= S_EXEC;
            default: begin
              o_err_cnt <= sat_inc(o_err_cnt);
              state     <= S_IDLE;
            end
          endcase
        end
        // Data word never arriving: drop the header and count the error.
        S_DATA_POP: begin
          if (!i_rd_buf_empty) begin
            state <= S_DATA_WAIT;
          end else if (tmo_cnt == TMO_LAST) begin
            o_err_cnt <= sat_inc(o_err_cnt);
            hdr       <= 32'h0;
            state     <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
          end
        end
        S_DATA_WAIT: begin
          data  <= i_rd_data;
          state <= S_EXEC;
        end
        S_EXEC: begin
          case (opcode)
            OP_TRIM_START: o_trim_start <= data;
            OP_TRIM_END:   o_trim_end   <= data;
            OP_ONE_ZERO: begin
              o_one_value  <= data[31:16];
              o_zero_value <= data[15:0];
            end
            OP_PILOT_WR: begin
              o_pilot_addr  <= hdr[9:0];
              o_pilot_wdata <= data;
              o_pilot_we    <= 1'b1;
            end
            OP_MM_RESET:   o_mapmov_reset <= 1'b1;
            default: ;
          endcase
`ifdef RINGBUS_CMD_ACK_EN
          ack_sent <= 1'b0;
`endif
          state <= S_POST_EXEC;
        end
`ifdef RINGBUS_CMD_ACK_EN
        S_ACK: begin
          if (!ack_sent && i_write_ready) ack_sent <= 1'b1;
          else if (ack_sent && i_done_wr) state <= S_IDLE;
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ringbus_cmd_decoder.sv
// Scoreboard bench for ringbus_cmd_decoder (default build): a receive-buffer model feeds
// directed command words, expected output events are queued and matched by a monitor.
module tb_ringbus_cmd_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] rd_data = 32'h0;
  logic        rd_empty = 1'b1;
  logic        rd_en;
  logic [31:0] wr_data, wr_addr;
  logic        start_wr;
  logic        write_ready = 1'b0;
  logic        done_wr = 1'b0;
  logic [31:0] trim_start, trim_end, pilot_wdata;
  logic [15:0] one_value, zero_value;
  logic [9:0]  pilot_addr;
  logic        pilot_we, mapmov_reset;
  logic [7:0]  err_cnt;

  always #5 clk = ~clk;

  ringbus_cmd_decoder dut (
    .i_sysclk(clk), .i_arst_n(rst_n),
    .i_rd_data(rd_data), .i_rd_buf_empty(rd_empty), .o_rd_en(rd_en),
    .o_wr_data(wr_data), .o_wr_addr(wr_addr), .o_start_wr(start_wr),
    .i_write_ready(write_ready), .i_done_wr(done_wr),
    .o_trim_start(trim_start), .o_trim_end(trim_end),
    .o_one_value(one_value), .o_zero_value(zero_value),
    .o_pilot_addr(pilot_addr), .o_pilot_wdata(pilot_wdata), .o_pilot_we(pilot_we),
    .o_mapmov_reset(mapmov_reset), .o_err_cnt(err_cnt)
  );

  localparam int K_TS = 0, K_TE = 1, K_OZ = 2, K_PIL = 3, K_MMR = 4, K_ERR = 5;

  typedef struct {
    int          kind;
    logic [31:0] a;
    logic [31:0] v;
  } ev_t;

  ev_t         exp_q[$];
  logic [31:0] fifo[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          lat_pop = 0, lat_upd = 0;
  bit          lat_arm = 0, lat_meas = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Receive buffer: the popped word appears the cycle after o_rd_en.
  always @(posedge clk) begin
    if (rd_en) begin
      #1;
      if (fifo.size() > 0) rd_data = fifo.pop_front();
      rd_empty = (fifo.size() == 0);
    end
  end

  task automatic push(input logic [31:0] w);
    fifo.push_back(w);
    rd_empty = 1'b0;
  endtask

  task automatic expect_ev(input int k, input logic [31:0] a, input logic [31:0] v);
    ev_t e;
    e.kind = k; e.a = a; e.v = v;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic observe(input int k, input logic [31:0] a, input logic [31:0] v);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event: got kind=%0d a=%h v=%h expected none", k, a, v);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || e.a !== a || e.v !== v) begin
        bad++;
        $display("FAIL event: got kind=%0d a=%h v=%h expected kind=%0d a=%h v=%h",
                 k, a, v, e.kind, e.a, e.v);
      end
    end
  endtask

  logic [31:0] p_ts, p_te;
  logic [15:0] p_one, p_zero;
  logic [7:0]  p_err;
  logic        p_we, p_mmr, p_rd;

  always @(negedge clk) begin
    if (!rst_n) begin
      p_ts = trim_start; p_te = trim_end; p_one = one_value; p_zero = zero_value;
      p_err = err_cnt; p_we = 1'b0; p_mmr = 1'b0; p_rd = 1'b0;
    end else begin
      if (rd_en) begin
        chk("rd_en_while_empty", {31'b0, rd_empty}, 32'h0);
        chk("rd_en_back_to_back", {31'b0, p_rd}, 32'h0);
        if (lat_arm) begin
          lat_pop = cyc + 1;
          lat_arm = 0;
        end
      end
      if (trim_start !== p_ts) begin
        observe(K_TS, 32'h0, trim_start);
        if (lat_meas) begin
          lat_upd  = cyc;
          lat_meas = 0;
        end
      end
      if (trim_end !== p_te) observe(K_TE, 32'h0, trim_end);
      if (one_value !== p_one || zero_value !== p_zero) observe(K_OZ, 32'h0, {one_value, zero_value});
      if (pilot_we) begin
        observe(K_PIL, {22'h0, pilot_addr}, pilot_wdata);
        chk("pilot_we_single_cycle", {31'b0, p_we}, 32'h0);
      end
      if (mapmov_reset) begin
        observe(K_MMR, 32'h0, 32'h0);
        chk("mapmov_single_cycle", {31'b0, p_mmr}, 32'h0);
      end
      if (err_cnt !== p_err) observe(K_ERR, 32'h0, {24'h0, err_cnt});
      p_ts = trim_start; p_te = trim_end; p_one = one_value; p_zero = zero_value;
      p_err = err_cnt; p_we = pilot_we; p_mmr = mapmov_reset; p_rd = rd_en;
    end
  end

  task automatic drain();
    int n = 0;
    while (fifo.size() != 0 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 5000) begin
      total++; bad++;
      $display("FAIL drain_timeout: got %0d words left expected 0", fifo.size());
    end
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_trim_start"}, trim_start, 32'h0);
    chk({tag, "_trim_end"}, trim_end, 32'h0);
    chk({tag, "_one_zero"}, {one_value, zero_value}, 32'h0);
    chk({tag, "_pilot"}, {pilot_we, mapmov_reset, 20'h0, pilot_addr} ^ pilot_wdata, 32'h0);
    chk({tag, "_err_cnt"}, {24'h0, err_cnt}, 32'h0);
    chk({tag, "_rd_en"}, {31'h0, rd_en}, 32'h0);
  endtask

  initial begin
    logic [7:0] e;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;

    // TRIM_START, with header-pop-to-update latency measured
    lat_arm = 1; lat_meas = 1;
    expect_ev(K_TS, 32'h0, 32'h0000_1234);
    push(32'h1000_0000); push(32'h0000_1234);
    drain();
    chk("trim_start_latency", lat_upd - lat_pop, 32'd5);

    expect_ev(K_PIL, 32'h0000_0155, 32'hDEAD_BEEF);
    push(32'h1300_0155); push(32'hDEAD_BEEF);
    drain();

    // unused payload bits in the header are ignored
    expect_ev(K_OZ, 32'h0, 32'h1111_2222);
    push(32'h12AB_CD00); push(32'h1111_2222);
    drain();

    // ack handshake inputs must have no effect in this build
    write_ready = 1'b1; done_wr = 1'b1;
    expect_ev(K_TE, 32'h0, 32'h0000_00AB);
    push(32'h11FF_FFFF); push(32'h0000_00AB);
    drain();

    expect_ev(K_MMR, 32'h0, 32'h0);
    push(32'h1412_3456);
    drain();
    chk("wr_data_tied", wr_data, 32'h0);
    chk("wr_addr_tied", wr_addr, 32'h0);
    chk("start_wr_tied", {31'h0, start_wr}, 32'h0);
    write_ready = 1'b0; done_wr = 1'b0;

    // data word missing: timeout after 4096 empty cycles, late word is a header
    expect_ev(K_ERR, 32'h0, 32'h1);
    push(32'h1100_0000);
    repeat (4120) @(posedge clk); #1;
    chk("timeout_err_cnt", {24'h0, err_cnt}, 32'h1);
    chk("timeout_trim_end_kept", trim_end, 32'h0000_00AB);
    expect_ev(K_ERR, 32'h0, 32'h2);
    push(32'h0000_00AB);
    drain();
    chk("late_word_trim_end_kept", trim_end, 32'h0000_00AB);

    // unknown opcode flood: counter saturates
    e = 8'd2;
    for (int i = 0; i < 300; i++) begin
      if (e != 8'hFF) begin
        e = e + 8'd1;
        expect_ev(K_ERR, 32'h0, {24'h0, e});
      end
      push(32'h7700_0000);
    end
    drain();
    chk("err_cnt_saturated", {24'h0, err_cnt}, 32'hFF);
    expect_ev(K_TS, 32'h0, 32'h0000_0055);
    push(32'h1000_0000); push(32'h0000_0055);
    drain();

    // reset between ONE_ZERO header and its data word
    push(32'h1200_0000);
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    @(negedge clk);
    chk_all_zero("midcmd_reset");
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    expect_ev(K_MMR, 32'h0, 32'h0);
    push(32'h1400_0000);
    drain();
    chk("post_reset_one_zero", {one_value, zero_value}, 32'h0);
    chk("post_reset_err_cnt", {24'h0, err_cnt}, 32'h0);

    chk("events_outstanding", exp_q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ringbus_cmd_decoder.md
RINGBUS_CMD_DECODER -- requirements
Module: ringbus_cmd_decoder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 4096: maximum cycles to wait for a data word.
REQ-002 SHALL have parameter ACK_ADDR, default 32'h0000_0000: ring bus destination address for ack words.
REQ-003 SHALL have port i_sysclk, input, 1 bit: single clock; all logic is rising-edge.
REQ-004 SHALL have port i_arst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port i_rd_data, input, 32 bits: ring bus receive word, valid the cycle after o_rd_en.
REQ-006 SHALL have port i_rd_buf_empty, input, 1 bit: ring bus receive buffer empty.
REQ-007 SHALL have port o_rd_en, output, 1 bit: single-cycle pop of the receive buffer.
REQ-008 SHALL have ports o_wr_data (output, 32), o_wr_addr (output, 32), o_start_wr (output, 1), i_write_ready (input, 1) and i_done_wr (input, 1): the ack transmit handshake.
REQ-009 SHALL have outputs o_trim_start (32), o_trim_end (32), o_one_value (16) and o_zero_value (16): registered mapmov configuration.
REQ-010 SHALL have outputs o_pilot_addr (10), o_pilot_wdata (32) and o_pilot_we (1): pilot RAM write port.
REQ-011 SHALL have output o_mapmov_reset, 1 bit: single-cycle mapmov reset pulse.
REQ-012 SHALL have output o_err_cnt, 8 bits: saturating error counter.

Function
REQ-013 Header word format SHALL be [31:24] opcode and [23:0] payload; opcodes: 0x10 TRIM_START, 0x11 TRIM_END, 0x12 ONE_ZERO and 0x13 PILOT_WR are two-word commands; 0x14 MM_RESET is a one-word command.
REQ-014 FSM states SHALL be IDLE, HDR_WAIT, DECODE, DATA_POP, DATA_WAIT, EXEC and ACK (ACK exists only with the macro).
REQ-015 IDLE: when !i_rd_buf_empty, SHALL assert o_rd_en for one cycle and go to HDR_WAIT; HDR_WAIT SHALL latch i_rd_data and go to DECODE.
REQ-016 o_rd_en SHALL never be asserted while i_rd_buf_empty=1 and SHALL never be asserted on two consecutive cycles.
REQ-017 DECODE: a two-word opcode SHALL go to DATA_POP; MM_RESET SHALL go to EXEC; any other opcode SHALL increment o_err_cnt and return to IDLE.
REQ-018 DATA_POP: when !empty, SHALL pulse o_rd_en and go to DATA_WAIT, which latches the data word and goes to EXEC.
REQ-019 A 32-bit timeout counter SHALL run while in DATA_POP with empty=1; at TIMEOUT_CYCLES it SHALL increment o_err_cnt, discard the header and return to IDLE with no outputs changed.
REQ-020 EXEC updates: TRIM_START sets o_trim_start=data; TRIM_END sets o_trim_end=data; ONE_ZERO sets o_one_value=data[31:16] and o_zero_value=data[15:0]; PILOT_WR sets o_pilot_addr=payload[9:0], o_pilot_wdata=data and pulses o_pilot_we for exactly one cycle; MM_RESET pulses o_mapmov_reset for exactly one cycle.
REQ-021 Register updates SHALL be visible the cycle after EXEC; minimum header-to-update latency SHALL be 5 cycles.
REQ-022 o_err_cnt SHALL saturate at 8'hFF.
REQ-023 Payload bits not used by an opcode SHALL be ignored.

Reset
REQ-024 Asserting i_arst_n low SHALL immediately force the FSM to IDLE and clear all outputs, counters and latched words to 0, including mid-command and mid-ack; after release, the next header SHALL be taken as a fresh command.

Configuration
REQ-025 Macro RINGBUS_CMD_ACK_EN defined: after EXEC the FSM SHALL enter ACK, wait for i_write_ready, drive o_wr_addr=ACK_ADDR and o_wr_data={8'hA5, opcode, 16'h0000}, pulse o_start_wr for one cycle, and stay in ACK until i_done_wr, then return to IDLE; no pops SHALL occur while in ACK.
REQ-026 Macro RINGBUS_CMD_ACK_EN undefined: EXEC SHALL go directly to IDLE, o_start_wr/o_wr_data/o_wr_addr SHALL be tied 0, and i_write_ready/i_done_wr SHALL be ignored.

Verification
REQ-027 Push 0x1000_0000 then 0x0000_1234 -> o_trim_start=0x1234 five cycles after the first pop; no other output changes.
REQ-028 Push 0x1300_0155 then 0xDEAD_BEEF -> o_pilot_we high exactly one cycle with o_pilot_addr=0x155 and o_pilot_wdata=0xDEADBEEF.
REQ-029 Push 0x7700_0000 (unknown opcode) 300 times -> o_err_cnt=0xFF with no wrap; FSM back in IDLE; next valid command executes correctly.
REQ-030 Push 0x1100_0000 alone, keep buffer empty for 4096 cycles -> o_err_cnt +1 and o_trim_end unchanged; a later data word is treated as a header.
REQ-031 Assert i_arst_n low between header and data of ONE_ZERO, push the data word after release -> o_one_value and o_zero_value remain 0 and the data word decodes as a header.
REQ-032 With RINGBUS_CMD_ACK_EN, send MM_RESET with i_write_ready held low for 20 cycles -> o_mapmov_reset pulses once, o_start_wr waits for ready, o_wr_data=0xA514_0000, and no pops occur until i_done_wr.
